// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch slice.
//   NOP_INSTR     : word presented on id_instr while the queue is empty
//   fetch_state_e : fetch FSM states (a fault is tracked separately, see
//                   fetch_fault in fetch_unit)
//   iq_entry_t    : one prefetch-queue entry {instr, pc}
//   is_aligned()  : word-alignment test used on redirect targets
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } iq_entry_t;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch stage's bus signals:
//   imem_addr / imem_data        : instruction-memory address and the
//                                  combinational word returned for it
//   id_valid / id_ready          : decode handshake
//   id_instr / id_pc             : head instruction and its PC
//   redirect_valid / redirect_pc : flush-and-restart request
// Modports:
//   master : the fetch unit
//   slave  : the environment (memory, decode, execute/CSR)
//
// Handshake: a transfer to decode happens on a rising clock edge where
// id_valid && id_ready are both high. id_valid never depends on id_ready, and
// id_instr/id_pc hold steady while id_valid=1 && id_ready=0. id_ready may
// toggle freely while id_valid=0 with no effect. redirect_valid is a
// single-cycle command that overrides any transfer in the same cycle.
// -----------------------------------------------------------------------------
interface fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Synchronous circular-buffer FIFO of iq_entry_t with flush.
// Parameters:
//   DEPTH : number of entries (power of 2, >= 2)
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : empty the queue; same-cycle push/pop are discarded
//   push, wdata  : write an entry (accepted when not full, or full with pop)
//   pop          : remove the head entry (ignored when empty)
//   head         : current head entry (register contents)
//   full, empty  : occupancy flags
// Pointers carry one extra MSB so full and empty are distinguishable when the
// index bits are equal.
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      flush,
  input  logic      push,
  input  iq_entry_t wdata,
  input  logic      pop,
  output iq_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  iq_entry_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full queue is fine when the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign do_push = push && (!full || pop) && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: empty gates every use of the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, addresses instruction memory, and
// captures {instr, pc} into a prefetch queue that feeds decode over a
// valid/ready handshake. Redirects flush the queue and restart fetch; a
// misaligned redirect target raises a sticky fault that inhibits fetch until
// the next aligned redirect.
// Parameters:
//   RESET_PC    : PC loaded on reset
//   QUEUE_DEPTH : prefetch queue entries (power of 2, >= 2)
//   IMEM_LIMIT  : first byte address past the program; no fetch at/above it
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   bus            : fetch_unit_if.master (imem, decode and redirect signals)
//   fetch_fault    : sticky misaligned-redirect flag
//   fetch_fault_pc : offending redirect target
//   fetch_idle     : nothing left to fetch (or faulted) and queue empty
//   dbg_state      : fetch FSM state
//   perf_fetched, perf_stall, perf_flush : event counters, present only when
//                    FETCH_PERF_CNT_EN is defined
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] IMEM_LIMIT  = 32'd188
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master bus,
  output logic         fetch_fault,
  output logic [31:0]  fetch_fault_pc,
  output logic         fetch_idle,
  output fetch_state_e dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall,
  output logic [31:0]  perf_flush
`endif
);

  logic [31:0]  pc_q;
  logic         fault_q;
  logic [31:0]  fault_pc_q;
  fetch_state_e state_q;

  logic         q_full;
  logic         q_empty;
  iq_entry_t    q_head;
  iq_entry_t    q_wdata;
  logic         pop;
  logic         below_limit;
  logic         fetch_en;

  assign below_limit = (pc_q < IMEM_LIMIT);
  assign pop         = bus.id_valid && bus.id_ready;
  assign fetch_en    = !fault_q && below_limit && (!q_full || pop);

  assign q_wdata.instr = bus.imem_data;
  assign q_wdata.pc    = pc_q;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (bus.redirect_valid),
    .push    (fetch_en),
    .wdata   (q_wdata),
    .pop     (pop),
    .head    (q_head),
    .full    (q_full),
    .empty   (q_empty)
  );

  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = !q_empty;
  assign bus.id_instr  = q_empty ? NOP_INSTR : q_head.instr;
  assign bus.id_pc     = q_empty ? 32'h0     : q_head.pc;

  assign fetch_fault    = fault_q;
  assign fetch_fault_pc = fault_pc_q;
  assign fetch_idle     = (!below_limit || fault_q) && q_empty;
  assign dbg_state      = state_q;

  // PC, fault flag and fetch FSM. A redirect wins over everything else in the
  // cycle; the queue side of the flush lives in fetch_queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
      state_q    <= RUN;
    end else if (bus.redirect_valid) begin
      pc_q <= bus.redirect_pc;
      if (is_aligned(bus.redirect_pc)) begin
        fault_q <= 1'b0;
        state_q <= RUN;
      end else begin
        // Faulted: the queue is flushed and nothing will be fetched.
        fault_q    <= 1'b1;
        fault_pc_q <= bus.redirect_pc;
        state_q    <= IDLE;
      end
    end else begin
      if (fetch_en) pc_q <= pc_q + 32'd4;
      case (state_q)
        RUN: begin
          if (!below_limit) state_q <= q_empty ? IDLE : DRAIN;
        end
        DRAIN: begin
          if (q_empty) state_q <= IDLE;
        end
        IDLE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
      perf_flush   <= 32'h0;
    end else begin
      if (fetch_en && !bus.redirect_valid) perf_fetched <= perf_fetched + 32'd1;
      if (q_full && !pop)                  perf_stall   <= perf_stall + 32'd1;
      if (bus.redirect_valid)              perf_flush   <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. The expected instruction stream is the
// program read in order from the current start PC up to IMEM_LIMIT; every
// reset or redirect replaces it. A negedge monitor pops that stream on each
// decode transfer and also checks fetch_idle and the fault flag.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned LIMIT = 188;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         fetch_fault;
  logic [31:0]  fetch_fault_pc;
  logic         fetch_idle;
  fetch_state_e dbg_state;

  fetch_unit_if bus ();

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (4),
    .IMEM_LIMIT  (32'd188)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .fetch_fault    (fetch_fault),
    .fetch_fault_pc (fetch_fault_pc),
    .fetch_idle     (fetch_idle),
    .dbg_state      (dbg_state)
  );

  // Instruction memory: combinational read of the program image.
  logic [31:0] prog [64];
  always_comb begin
    bus.imem_data = 32'h0;
    if (bus.imem_addr < 32'd188) bus.imem_data = prog[bus.imem_addr[7:2]];
  end

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];          // {pc, instr}
  logic        model_fault;
  logic [31:0] model_fault_pc;
  bit          mon_en;
  logic [63:0] mon_e;
  logic [31:0] tgt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: after reset/redirect to target, decode must see exactly
  // the program words from target up to LIMIT, in order; a misaligned target
  // produces no instructions and a fault.
  task automatic load_stream(input logic [31:0] target);
    exp_q.delete();
    if (target[1:0] != 2'b00) begin
      model_fault    = 1'b1;
      model_fault_pc = target;
    end else begin
      model_fault = 1'b0;
      for (int unsigned a = target; a < LIMIT; a += 4)
        exp_q.push_back({a, prog[a[7:2]]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    load_stream(target);
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic sync_reset_pulse();
    reset_n = 1'b0;
    load_stream(32'h0);
    tick();
    reset_n = 1'b1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en && reset_n && !bus.redirect_valid) begin
      chk("idle", {31'h0, fetch_idle}, {31'h0, exp_q.size() == 0});
      chk("fault", {31'h0, fetch_fault}, {31'h0, model_fault});
      if (model_fault) chk("fault_pc", fetch_fault_pc, model_fault_pc);
      if (bus.id_valid && bus.id_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr: got pc %h instr %h expected none",
                   bus.id_pc, bus.id_instr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("stream_pc", bus.id_pc, mon_e[63:32]);
          chk("stream_instr", bus.id_instr, mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) prog[i] = $urandom;
    prog[0]  = 32'h0070_8093;
    prog[1]  = 32'h0031_0113;
    prog[2]  = 32'h00A0_0193;
    prog[7]  = 32'h0222_0233;
    prog[9]  = 32'h0052_4863;
    prog[46] = 32'h0000_8067;

    reset_n            = 1'b0;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    mon_en             = 1'b0;
    model_fault        = 1'b0;
    model_fault_pc     = 32'h0;

    // Reset values
    #2;
    chk("rst_id_valid", {31'h0, bus.id_valid}, 32'h0);
    chk("rst_id_instr", bus.id_instr, NOP_INSTR);
    chk("rst_id_pc", bus.id_pc, 32'h0);
    chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
    chk("rst_fault_pc", fetch_fault_pc, 32'h0);
    chk("rst_idle", {31'h0, fetch_idle}, 32'h0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    load_stream(32'h0);
    mon_en = 1'b1;

    // Streaming from reset: one-cycle latency then 1/cycle
    tick();
    reset_n = 1'b1;
    tick();
    chk("first_valid", {31'h0, bus.id_valid}, 32'h1);
    chk("first_pc", bus.id_pc, 32'h0);
    chk("first_instr", bus.id_instr, 32'h0070_8093);
    tick();
    chk("second_pc", bus.id_pc, 32'h4);
    chk("second_instr", bus.id_instr, 32'h0031_0113);
    tick();
    chk("third_pc", bus.id_pc, 32'h8);
    chk("third_instr", bus.id_instr, 32'h00A0_0193);

    // Backpressure: queue fills with exactly QUEUE_DEPTH entries
    bus.id_ready = 1'b0;
    sync_reset_pulse();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_pc", bus.id_pc, 32'h0);
      chk("hold_instr", bus.id_instr, 32'h0070_8093);
    end
    chk("hold_imem_addr", bus.imem_addr, 32'd16);
    chk("hold_state", 32'(dbg_state), 32'(RUN));
    bus.id_ready = 1'b1;
    repeat (6) tick();

    // Redirect while full, with a same-cycle pop/push that must be dropped
    bus.id_ready = 1'b0;
    repeat (6) tick();
    bus.id_ready = 1'b1;
    do_redirect(32'h1C);
    chk("redir_flush_valid", {31'h0, bus.id_valid}, 32'h0);
    chk("redir_imem_addr", bus.imem_addr, 32'h1C);
    tick();
    chk("redir_head_pc", bus.id_pc, 32'h1C);
    chk("redir_head_instr", bus.id_instr, 32'h0222_0233);
    tick();
    chk("redir_next_pc", bus.id_pc, 32'h20);

    // Misaligned redirect faults, aligned redirect recovers
    do_redirect(32'h22);
    chk("mis_fault", {31'h0, fetch_fault}, 32'h1);
    chk("mis_fault_pc", fetch_fault_pc, 32'h22);
    chk("mis_valid", {31'h0, bus.id_valid}, 32'h0);
    repeat (3) begin
      tick();
      chk("mis_no_push", {31'h0, bus.id_valid}, 32'h0);
      chk("mis_pc_frozen", bus.imem_addr, 32'h22);
    end
    do_redirect(32'h24);
    chk("recover_fault", {31'h0, fetch_fault}, 32'h0);
    tick();
    chk("recover_pc", bus.id_pc, 32'h24);
    chk("recover_instr", bus.id_instr, 32'h0052_4863);

    // End of program: last word, then drain to idle
    do_redirect(32'hB8);
    tick();
    chk("last_valid", {31'h0, bus.id_valid}, 32'h1);
    chk("last_pc", bus.id_pc, 32'hB8);
    chk("last_instr", bus.id_instr, 32'h0000_8067);
    repeat (4) tick();
    chk("end_idle", {31'h0, fetch_idle}, 32'h1);
    chk("end_imem_addr", bus.imem_addr, 32'hBC);
    chk("end_state", 32'(dbg_state), 32'(IDLE));
    chk("end_valid", {31'h0, bus.id_valid}, 32'h0);

    // Random backpressure and redirects
    for (int i = 0; i < 400; i++) begin
      bus.id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        tgt = 32'($urandom_range(0, 50)) * 32'd4;
        if ($urandom_range(0, 3) == 0) tgt = tgt + 32'($urandom_range(1, 3));
        do_redirect(tgt);
      end else begin
        tick();
      end
    end

    // Asynchronous reset between clock edges mid-stream
    bus.id_ready = 1'b1;
    do_redirect(32'h0);
    repeat (5) tick();
    #3;
    reset_n = 1'b0;
    load_stream(32'h0);
    #1;
    chk("arst_valid", {31'h0, bus.id_valid}, 32'h0);
    chk("arst_instr", bus.id_instr, NOP_INSTR);
    chk("arst_pc", bus.id_pc, 32'h0);
    chk("arst_imem_addr", bus.imem_addr, 32'h0);
    chk("arst_idle", {31'h0, fetch_idle}, 32'h0);
    chk("arst_fault", {31'h0, fetch_fault}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("restart_valid", {31'h0, bus.id_valid}, 32'h1);
    chk("restart_pc", bus.id_pc, 32'h0);
    repeat (60) tick();
    chk("stream_complete", exp_q.size(), 32'h0);
    chk("final_idle", {31'h0, fetch_idle}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
